shift_load_sequencer: RTL and testbench

//  Upstream feeder for the 4-bit bidirectional shift register. Accepts a parallel word plus direction

---
 rtl/shift_load_pkg.sv | 20 ++
 rtl/shift_load_bitsel.sv | 28 ++
 rtl/shift_load_sequencer.sv | 179 +++++++++++++++++
 tb/tb_shift_load_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_load_pkg.sv
// Shared types and constants for the shift-load sequencer.
// State encodings are plain constants so older tools and netlists see the same values.
package shift_load_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_load_bitsel.sv
// Combinational bit picker: left transfers go MSB first, right transfers go LSB first,
// so the downstream register ends up holding the word unchanged in both directions.
module shift_load_bitsel
  import shift_load_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic             dir,
  input  logic [CNT_W-1:0] idx,
  output logic             bit_o
);

  logic [CNT_W-1:0] rev_idx;

  // Mirror the index for MSB-first streaming.
  always_comb begin
    rev_idx = CNT_W'(WIDTH - 1) - idx;
    bit_o   = 1'b0;
    if (dir == DIR_LEFT) begin
      bit_o = word[rev_idx];
    end else begin
      bit_o = word[idx];
    end
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Streams a parallel word into a bidirectional shift register over WIDTH cycles.
// Optional read-back compare of the register contents is enabled by SHIFT_LOAD_CHECK_EN.
module shift_load_sequencer
  import shift_load_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             dir_in,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             serial_out,
  output logic             shift_left,
  output logic             shift_en,
  output logic             busy,
  output logic             done
`ifdef SHIFT_LOAD_CHECK_EN
  ,
  input  logic [WIDTH-1:0] data_chk,
  output logic             chk_ok
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             left_q, left_d;
  logic             serial_q, serial_d;
  logic             shift_en_q, shift_en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
`ifdef SHIFT_LOAD_CHECK_EN
  logic             chk_ok_q, chk_ok_d;
`endif

  logic [WIDTH-1:0] sel_word;
  logic             sel_dir;
  logic [CNT_W-1:0] sel_idx;
  logic             sel_bit;
  logic             accept;

  assign accept = start_valid & ready_q;

  // In IDLE the first bit comes straight from the inputs; afterwards from the latch.
  always_comb begin
    sel_word = word_q;
    sel_dir  = left_q;
    sel_idx  = cnt_q + CNT_W'(1);
    if (state_q == ST_IDLE) begin
      sel_word = word_in;
      sel_dir  = dir_in;
      sel_idx  = {CNT_W{1'b0}};
    end else begin
      sel_word = word_q;
      sel_dir  = left_q;
      sel_idx  = cnt_q + CNT_W'(1);
    end
  end

  shift_load_bitsel #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitsel (
    .word  (sel_word),
    .dir   (sel_dir),
    .idx   (sel_idx),
    .bit_o (sel_bit)
  );

  // Next-state and next-output logic; serial_out/shift_en default to the idle values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    left_d     = left_q;
    serial_d   = 1'b0;
    shift_en_d = 1'b0;
    done_d     = 1'b0;
`ifdef SHIFT_LOAD_CHECK_EN
    chk_ok_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SHIFT;
          cnt_d      = {CNT_W{1'b0}};
          word_d     = word_in;
          left_d     = dir_in;
          serial_d   = sel_bit;
          shift_en_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit is being sampled downstream on this edge.
          state_d = ST_DONE;
          cnt_d   = {CNT_W{1'b0}};
`ifndef SHIFT_LOAD_CHECK_EN
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          serial_d   = sel_bit;
          shift_en_d = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef SHIFT_LOAD_CHECK_EN
        state_d  = ST_CHECK;
        done_d   = 1'b1;
        chk_ok_d = (data_chk == word_q);
`else
        state_d  = ST_IDLE;
`endif
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      word_q     <= {WIDTH{1'b0}};
      left_q     <= 1'b0;
      serial_q   <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      left_q     <= left_d;
      serial_q   <= serial_d;
      shift_en_q <= shift_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

`ifdef SHIFT_LOAD_CHECK_EN
  // Compare result register, pulses alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_ok_q <= 1'b0;
    end else begin
      chk_ok_q <= chk_ok_d;
    end
  end

  assign chk_ok = chk_ok_q;
`endif

  assign start_ready = ready_q;
  assign serial_out  = serial_q;
  assign shift_left  = left_q;
  assign shift_en    = shift_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Bench for shift_load_sequencer: timeline model checked every cycle plus literal expectations.
// A gated copy of the downstream bidirectional register is kept to confirm the loaded word.
module tb_shift_load_sequencer;

  localparam int W = 4;
`ifdef SHIFT_LOAD_CHECK_EN
  localparam int LAST = W + 1;
`else
  localparam int LAST = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] word_in = 4'b0000;
  logic         dir_in = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready, serial_out, shift_left, shift_en, busy, done;
  logic [W-1:0] dreg = 4'b0000;
  logic [W-1:0] cap = 4'b0000;
  logic         chk_bit;
`ifdef SHIFT_LOAD_CHECK_EN
  logic         force_zero = 1'b0;
  logic [W-1:0] data_chk;
  logic         chk_ok;
  assign data_chk = force_zero ? 4'b0000 : dreg;
  assign chk_bit  = chk_ok;
`else
  assign chk_bit  = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  shift_load_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .dir_in      (dir_in),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .serial_out  (serial_out),
    .shift_left  (shift_left),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done)
`ifdef SHIFT_LOAD_CHECK_EN
    ,
    .data_chk    (data_chk),
    .chk_ok      (chk_ok)
`endif
  );

  always #5 clk = ~clk;

  // Downstream register, shifting only while shift_en so it holds the word afterwards.
  always @(posedge clk) begin
    if (rst) dreg <= 4'b0000;
    else if (shift_en) dreg <= shift_left ? {dreg[2:0], serial_out} : {serial_out, dreg[3:1]};
  end

  // Records the serial stream in arrival order.
  always @(negedge clk) begin
    if (shift_en) cap <= {cap[2:0], serial_out};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
  endtask

  function automatic logic mbit(input logic [W-1:0] w, input logic d, input int t);
    return d ? w[W-1-t] : w[t];
  endfunction

  // Timeline model: a transfer accepted at edge A owns cycles A..A+LAST.
  bit          act = 1'b0;
  int          acc = 0;
  logic [W-1:0] mw = 4'b0000;
  logic        md = 1'b0;
  logic        mbusy = 1'b0;
  logic [6:0]  exp_vec = 7'b1000000;

  always @(posedge clk) begin : model_blk
    int t;
    logic [6:0] e;
    cyc = cyc + 1;
    if (rst) begin
      act = 1'b0;
      md  = 1'b0;
    end else if (!mbusy && start_valid) begin
      act = 1'b1;
      acc = cyc;
      mw  = word_in;
      md  = dir_in;
    end
    t = cyc - acc;
    if (act && t > LAST) act = 1'b0;
    // {ready, busy, shift_en, done, serial, shift_left, chk_ok}
    e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, md, 1'b0};
    if (act) begin
      e[6] = 1'b0;
      e[5] = 1'b1;
      if (t < W) begin
        e[4] = 1'b1;
        e[2] = mbit(mw, md, t);
      end else if (t == LAST) begin
        e[3] = 1'b1;
`ifdef SHIFT_LOAD_CHECK_EN
        e[0] = (data_chk == mw);
`endif
      end
    end
    mbusy   = e[5];
    exp_vec = e;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc >= 1)
      check("cycle", {25'd0, start_ready, busy, shift_en, done, serial_out, shift_left, chk_bit},
            {25'd0, exp_vec});
  end

  task automatic send(input logic [W-1:0] w, input logic d);
    bit ok = 1'b0;
    @(negedge clk);
    word_in = w;
    dir_in = d;
    start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (start_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(output int dcyc);
    bit ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    check("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int dc;
    int gap;
    int done_seen;
    bit ok;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {26'd0, start_ready, busy, shift_en, done, serial_out, shift_left},
          32'b100000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {26'd0, start_ready, busy, shift_en, done, serial_out, shift_left},
          32'b100000);

    // Left, MSB first
    send(4'b1011, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_done(dc);
    check("left_serial_seq", {28'd0, cap}, 32'b1011);
    check("left_data_out", {28'd0, dreg}, 32'b1011);
    check("left_dir_held", {31'd0, shift_left}, 32'd1);
`ifdef SHIFT_LOAD_CHECK_EN
    check("left_chk_ok", {31'd0, chk_ok}, 32'd1);
`endif

    // Right, LSB first
    send(4'b1011, 1'b0);
    @(negedge clk);
    start_valid = 1'b0;
    wait_done(dc);
    check("right_serial_seq", {28'd0, cap}, 32'b1101);
    check("right_data_out", {28'd0, dreg}, 32'b1011);
    check("right_dir_held", {31'd0, shift_left}, 32'd0);

    // Valid held high across two transfers; inputs change mid-transfer
    send(4'b0110, 1'b1);
    @(negedge clk);
    word_in = 4'b1001;
    dir_in = 1'b0;
    wait_done(dc);
    check("b2b_first_data", {28'd0, dreg}, 32'b0110);
    ok = 1'b0;
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (shift_en) begin
        ok = 1'b1;
        gap = cyc - dc;
        break;
      end
    end
    check("b2b_restart_timeout", {31'd0, ok}, 32'd1);
    check("b2b_idle_gap", gap, 32'd2);
    start_valid = 1'b0;
    wait_done(dc);
    check("b2b_second_data", {28'd0, dreg}, 32'b1001);
    check("b2b_second_seq", {28'd0, cap}, 32'b1001);

    // Reset during the second shift cycle
    send(4'b0101, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", {26'd0, start_ready, busy, shift_en, done, serial_out, shift_left},
          32'b100000);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

`ifdef SHIFT_LOAD_CHECK_EN
    force_zero = 1'b1;
    send(4'b1011, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_done(dc);
    check("forced_chk_ok", {31'd0, chk_ok}, 32'd0);
    force_zero = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
